// File: rtl/layer_seq_if.sv
// layer_seq_if: configuration, control and datapath-setup signals of the layer sequencer
interface layer_seq_if;
  logic        cfg_wren_i;
  logic [2:0]  cfg_addr_i;
  logic [28:0] cfg_wdata_i;
  logic [3:0]  num_layers_i;
  logic        run_i;
  logic        abort_i;
  logic        layer_done_i;
  logic [1:0]  start_o;
  logic [1:0]  nth_conv_o;
  logic [4:0]  ofmap_size_o;
  logic [5:0]  ifmap_ch_o;
  logic [6:0]  in_node_num_o;
  logic [6:0]  out_node_num_o;
  logic [2:0]  layer_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  modport master (
    output cfg_wren_i, cfg_addr_i, cfg_wdata_i, num_layers_i, run_i, abort_i, layer_done_i,
    input  start_o, nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o,
           layer_idx_o, busy_o, done_o, err_o
  );
  modport slave (
    input  cfg_wren_i, cfg_addr_i, cfg_wdata_i, num_layers_i, run_i, abort_i, layer_done_i,
    output start_o, nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o,
           layer_idx_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/layer_seq.sv
// layer_seq: steps through a table of conv/FC layer descriptors, driving datapath start and config
module layer_seq #(
  parameter int MAX_LAYERS  = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic         clk,
  input logic         rst_n,
  layer_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, FIN, ERR} state_t;
  state_t      state, state_nx;
  logic [28:0] tbl [MAX_LAYERS];
  logic [28:0] ent;
  logic [26:0] cfg;
  logic [15:0] cnt;
  logic [3:0]  num, num_clamp;
  logic [2:0]  idx;
  logic [1:0]  start;
  logic        err, valid, last, gap_end, tmo;
  assign ent       = tbl[idx];
  assign valid     = ^ent[28:27];
  assign num_clamp = (bus.num_layers_i > 4'(MAX_LAYERS)) ? 4'(MAX_LAYERS) : bus.num_layers_i;
  assign last      = {1'b0, idx} == num - 4'd1;
  assign gap_end   = cnt == 16'(GAP_CYC - 1);
  // the RUN cycle holding TIMEOUT_CYC-1 is the last one allowed; a done pulse there still wins
  assign tmo       = cnt == 16'(TIMEOUT_CYC - 1);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.run_i) state_nx = (num_clamp == 4'd0) ? FIN : LOAD;
      LOAD:    state_nx = valid ? RUN : ERR;
      RUN:     state_nx = bus.layer_done_i ? (last ? FIN : GAP) : (tmo ? ERR : RUN);
      GAP:     if (gap_end) state_nx = LOAD;
      FIN:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort_i && state != IDLE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      num   <= '0;
      idx   <= '0;
      cnt   <= '0;
      start <= '0;
      cfg   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx == state && (state == RUN || state == GAP)) ? cnt + 16'd1 : '0;
      start <= (state_nx == RUN) ? ((state == RUN) ? start : ent[28:27]) : 2'd0;
      if (state == LOAD) cfg <= ent[26:0];
      if (state == IDLE && bus.run_i && num_clamp != 4'd0) begin
        num <= num_clamp;
        idx <= '0;
      end
      if (state == GAP && state_nx == LOAD) idx <= idx + 3'd1;
      if (state_nx == ERR) err <= 1'b1;
      else if (state == IDLE && bus.run_i) err <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) tbl[i] <= '0;
    end else if (bus.cfg_wren_i && state == IDLE) begin
      tbl[bus.cfg_addr_i] <= bus.cfg_wdata_i;
    end
  end
  assign bus.start_o     = start;
  assign {bus.nth_conv_o, bus.ofmap_size_o, bus.ifmap_ch_o, bus.in_node_num_o, bus.out_node_num_o} = cfg;
  assign bus.layer_idx_o = idx;
  assign bus.busy_o      = state != IDLE;
  assign bus.done_o      = state == FIN;
  assign bus.err_o       = err;
endmodule

// File: doc/layer_seq.md
LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 Parameter MAX_LAYERS, default 8, is the layer-table depth (entries 0..MAX_LAYERS-1; index width 3 bits).
REQ-002 Parameter GAP_CYC, default 4, is the number of idle cycles inserted between consecutive layers for pipeline drain.
REQ-003 Parameter TIMEOUT_CYC, default 65535, is the maximum RUN cycles per layer before error (counter 16 bits).
REQ-004 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_wren_i  in  1  layer-table write strobe.
- cfg_addr_i  in  3  table entry index.
- cfg_wdata_i  in  29  entry {type[28:27], nth_conv[26:25], ofmap_size[24:20], ifmap_ch[19:14], in_node[13:7], out_node[6:0]}.
- num_layers_i  in  4  layers to execute, 0..MAX_LAYERS.
- run_i  in  1  single-cycle start pulse.
- abort_i  in  1  single-cycle abort pulse.
- layer_done_i  in  1  single-cycle completion pulse from the datapath.
- start_o  out  2  datapath start code: 0 wait, 1 conv (SA), 2 FC.
- nth_conv_o  out  2; ofmap_size_o  out  5; ifmap_ch_o  out  6; in_node_num_o  out  7; out_node_num_o  out  7  datapath configuration.
- layer_idx_o  out  3  current layer index.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the sequence completes.
- err_o  out  1  sticky error flag.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, RUN, GAP, FIN, ERR.
REQ-006 A table write SHALL occur when cfg_wren_i=1 and busy_o=0; writes while busy SHALL be ignored.
REQ-007 IDLE: run_i=1 SHALL clear err_o and go to FIN if num_layers_i=0; otherwise it SHALL latch num_layers_i, set layer_idx_o=0, and go to LOAD.
REQ-008 num_layers_i>MAX_LAYERS SHALL be treated as MAX_LAYERS.
REQ-009 LOAD (1 cycle): all config outputs SHALL be registered from entry layer_idx_o; type 1 or 2 SHALL go to RUN; type 0 or 3 SHALL go to ERR.
REQ-010 RUN: start_o SHALL equal the entry type and be held; config outputs SHALL remain stable; the timeout counter SHALL increment each cycle from 0.
REQ-011 Latency: run_i in cycle N SHALL give start_o!=0 in cycle N+2.
REQ-012 layer_done_i in RUN SHALL set start_o=0 the next cycle; if layer_idx_o=latched count-1 go to FIN, else go to GAP.
REQ-013 GAP SHALL last exactly GAP_CYC cycles with start_o=0, then increment layer_idx_o and go to LOAD.
REQ-014 FIN (1 cycle): done_o=1, then IDLE; layer_idx_o SHALL hold the last index.
REQ-015 If the RUN counter reaches TIMEOUT_CYC without layer_done_i, the FSM SHALL go to ERR; layer_done_i in that same cycle SHALL win (normal completion).
REQ-016 ERR: err_o=1, start_o=0, one cycle, then IDLE; err_o SHALL stay 1 until the next accepted run_i.
REQ-017 abort_i in any non-IDLE state SHALL force start_o=0 and return to IDLE the next cycle without done_o or err_o; abort_i SHALL win over a simultaneous layer_done_i or run_i.
REQ-018 run_i while busy_o=1 SHALL be ignored; layer_done_i outside RUN SHALL be ignored.

Reset
REQ-019 On rst_n=0 the block SHALL enter IDLE asynchronously with all outputs 0 and counters 0.
REQ-020 Table contents SHALL reset to 0 (type 0, i.e. an invalid entry).
REQ-021 Reset mid-RUN SHALL drop start_o to 0 immediately, without waiting for a clock edge.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Load 5 entries (conv nth=0 ofmap 28 ch 1; conv nth=1 ofmap 10 ch 6; fc 120->84 ×3 varied), num_layers_i=5, run_i, done 20 cycles into each RUN -> start_o sequence 1,1,2,2,2, 4-cycle gaps, one done_o, err_o=0.
- run_i at cycle 10 -> start_o=1 at cycle 12; layer_done_i at 30 -> start_o=0 at 31.
- Entry 1 type=3 -> ERR after layer 0; err_o=1, layer_idx_o=1, start_o never 3.
- TIMEOUT_CYC=100, no layer_done_i -> err_o=1 after 100 RUN cycles; a done pulse in the expiry cycle -> no error.
- abort_i together with layer_done_i mid-layer 2 -> IDLE next cycle, done_o=0, err_o=0; cfg write during busy leaves table unchanged.
- num_layers_i=0 -> done_o 1 cycle after run_i, start_o stays 0.
